// File: rtl/rr_grant_responder.sv
// Resource-side responder for a round-robin arbiter: latches the one-hot grant as
// owner, serves it for a per-requester length, then pulses ack/done and counts the transaction.
module rr_grant_responder #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [WIDTH-1:0]       grant,
  input  logic [WIDTH*LEN_W-1:0] svc_len,
  output logic                   ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       owner,
  output logic [WIDTH-1:0]       done,
  output logic                   err,
  output logic [CNT_W-1:0]       txn_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] owner_q, done_q;
  logic [CNT_W-1:0] txn_cnt_q;
  logic             ack_q, busy_q, err_q, viol_q;

  logic [LEN_W-1:0] len_sel, len_d;
  logic             grant_hot, viol_d, err_d;

  assign grant_hot = $onehot(grant);

  // Only the granted field survives the mask, so OR-reduction selects it.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < WIDTH; i++)
      len_sel = len_sel | (svc_len[i*LEN_W +: LEN_W] & {LEN_W{grant[i]}});
    len_d = (len_sel == '0) ? LEN_W'(1) : len_sel;
  end

  // A violation that persists over several cycles raises err only on its first cycle.
  always_comb begin
    viol_d = 1'b0;
    case (state_q)
      IDLE:    viol_d = (grant != '0) && !grant_hot;
      SERVE:   viol_d = (grant != owner_q);
      default: viol_d = 1'b0;
    endcase
    err_d = viol_d && !viol_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      done_q    <= '0;
      txn_cnt_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= '0;
      err_q  <= err_d;
      viol_q <= viol_d;
      case (state_q)
        IDLE: begin
          if (grant_hot) begin
            owner_q <= grant;
            cnt_q   <= len_d;
            busy_q  <= 1'b1;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          if (cnt_q == LEN_W'(1)) begin
            ack_q     <= 1'b1;
            done_q    <= owner_q;
            txn_cnt_q <= txn_cnt_q + CNT_W'(1);
            state_q   <= ACK;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        ACK: begin
          owner_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign done    = done_q;
  assign err     = err_q;
  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_rr_grant_responder.sv
// Bench for rr_grant_responder: table of grant transactions, per-cycle expected
// outputs queued at drive time and popped on each falling edge.
module tb_rr_grant_responder;
  localparam int W  = 4;
  localparam int LW = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            resetb;
  logic [W-1:0]    grant;
  logic [W*LW-1:0] svc_len;
  logic            ack, busy, err;
  logic [W-1:0]    owner, done;
  logic [CW-1:0]   txn_cnt;

  rr_grant_responder #(.WIDTH(W), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .resetb(resetb), .grant(grant), .svc_len(svc_len),
    .ack(ack), .busy(busy), .owner(owner), .done(done), .err(err), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ack;
    logic          busy;
    logic [W-1:0]  owner;
    logic [W-1:0]  done;
    logic          err;
    logic [CW-1:0] cnt;
  } obs_t;

  // len == 0 marks a multi-hot grant that must be rejected.
  typedef struct {
    logic [W-1:0]    g;
    logic [W*LW-1:0] s;
    int              len;
    int              sw_at;
    logic [W-1:0]    sw_g;
  } vec_t;

  obs_t          sb[$];
  int            n_chk = 0;
  int            n_pass = 0;
  logic [CW-1:0] exp_cnt;
  vec_t          vecs[12];

  task automatic check_obs(input string nm, input int idx);
    obs_t act, exp;
    act = {ack, busy, owner, done, err, txn_cnt};
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s[%0d]: scoreboard empty, got %h", nm, idx, act);
    end else begin
      exp = sb.pop_front();
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic push_idle(input int n);
    obs_t r;
    for (int i = 0; i < n; i++) begin
      r = {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, exp_cnt};
      sb.push_back(r);
    end
  endtask

  task automatic drain(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check_obs(nm, i);
    end
  endtask

  // Called just after a falling edge; grant is sampled on the next rising edge.
  task automatic run_txn(input string nm, input vec_t v);
    obs_t r;
    logic e;
    int   n;
    grant   = v.g;
    svc_len = v.s;
    if (v.len == 0) begin
      r = {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b1, exp_cnt};
      sb.push_back(r);
      push_idle(1);
      n = 2;
    end else begin
      for (int i = 0; i < v.len; i++) begin
        e = (v.sw_at >= 0) && (v.sw_g != v.g) && (i == v.sw_at + 1);
        r = {1'b0, 1'b1, v.g, {W{1'b0}}, e, exp_cnt};
        sb.push_back(r);
      end
      exp_cnt = exp_cnt + 1'b1;
      e = (v.sw_at >= 0) && (v.sw_g != v.g) && (v.len == v.sw_at + 1);
      r = {1'b1, 1'b1, v.g, v.g, e, exp_cnt};
      sb.push_back(r);
      push_idle(1);
      n = v.len + 2;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check_obs(nm, i);
      if (i == v.sw_at) begin
        grant   = v.sw_g;
        svc_len = ~v.s;
      end
      if ((v.len == 0 && i == 1) || (v.len > 0 && i == v.len)) grant = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v1;
    vecs[0]  = '{4'b0010, 16'h0030, 3,  -1, 4'b0000};
    vecs[1]  = '{4'b0001, 16'h0000, 1,  -1, 4'b0000};
    vecs[2]  = '{4'b0110, 16'h0000, 0,  -1, 4'b0000};
    vecs[3]  = '{4'b0100, 16'h0200, 2,  -1, 4'b0000};
    vecs[4]  = '{4'b1000, 16'h5000, 5,   1, 4'b0001};
    vecs[5]  = '{4'b0100, 16'h0300, 3,   0, 4'b0100};
    vecs[6]  = '{4'b0010, 16'h00F0, 15, 14, 4'b0100};
    vecs[7]  = '{4'b1011, 16'hFFFF, 0,  -1, 4'b0000};
    vecs[8]  = '{4'b0001, 16'h4321, 1,  -1, 4'b0000};
    vecs[9]  = '{4'b0010, 16'h4321, 2,  -1, 4'b0000};
    vecs[10] = '{4'b0100, 16'h4321, 3,  -1, 4'b0000};
    vecs[11] = '{4'b1000, 16'h4321, 4,  -1, 4'b0000};

    resetb  = 1'b0;
    grant   = '0;
    svc_len = '0;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    push_idle(1);
    check_obs("reset", 0);
    resetb = 1'b1;
    push_idle(10);
    drain("idle", 10);

    for (int k = 0; k < 12; k++) run_txn($sformatf("vec%0d", k), vecs[k]);

    // Reset in the middle of a service: outputs clear at once, no ack follows.
    grant   = 4'b0100;
    svc_len = 16'h0500;
    @(posedge clk); @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); @(negedge clk);
    resetb = 1'b0;
    #1;
    check_val("rst_abort", {13'd0, ack, busy, owner, done, err, txn_cnt}, 32'd0);
    grant = '0;
    @(negedge clk);
    resetb  = 1'b1;
    exp_cnt = '0;
    push_idle(8);
    drain("post_rst", 8);

    v1 = '{4'b0001, 16'h0000, 1, -1, 4'b0000};
    for (int k = 0; k < 256; k++) run_txn($sformatf("wrap%0d", k), v1);
    check_val("wrap_cnt", {24'd0, txn_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
